// File: rtl/conv2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_pkg
//  Description : Shared constants, FSM state type and the round/saturate
//                helper for the conv2 output drain.
//                Optional feature macro: CONV2_DRAIN_RELU_EN
//                  defined   -> negative results clamp to 0 (ReLU), positive
//                               saturate at 127
//                  undefined -> signed saturation to [-128, 127]
//  Revision    : 1.0 - initial release
// ============================================================================
package conv2_pkg;

    localparam int CH      = 16;    // output channels per position
    localparam int ACC_W   = 30;    // signed accumulator width per channel
    localparam int DATA_W  = 8;     // signed output activation width
    localparam int BIAS_W  = 8;     // signed bias width
    localparam int SHIFT   = 9;     // accumulators carry a 2^SHIFT scale
    localparam int POS_MAX = 1260;  // positions per 30x42 frame

    localparam int CH_W  = 4;
    localparam int POS_W = 11;

    // Sum of accumulator and scaled bias needs one extra bit; the rounding
    // add needs one more so the half-LSB offset can never wrap.
    localparam int SUM_W = ACC_W + 1;
    localparam int RND_W = SUM_W + 1;
    localparam int Q_W   = RND_W - SHIFT;

    localparam logic signed [RND_W-1:0] c_half  = RND_W'(2**(SHIFT-1));
    localparam logic signed [Q_W-1:0]   c_q_max = Q_W'(2**(DATA_W-1) - 1);
    localparam logic signed [Q_W-1:0]   c_q_min = Q_W'(-(2**(DATA_W-1)));

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Round half up, arithmetic shift down by SHIFT, then clamp to DATA_W.
    function automatic logic signed [DATA_W-1:0] round_sat(
        input logic signed [SUM_W-1:0] sum
    );
        logic signed [RND_W-1:0] rnd;
        logic signed [Q_W-1:0]   q;
        rnd = {sum[SUM_W-1], sum} + c_half;
        // Taking the upper bits of a two's-complement value is exactly an
        // arithmetic right shift.
        q = rnd[RND_W-1:SHIFT];
`ifdef CONV2_DRAIN_RELU_EN
        if (q[Q_W-1]) begin
            return '0;
        end else if (q > c_q_max) begin
            return DATA_W'(c_q_max);
        end else begin
            return q[DATA_W-1:0];
        end
`else
        if (q > c_q_max) begin
            return DATA_W'(c_q_max);
        end else if (q < c_q_min) begin
            return DATA_W'(c_q_min);
        end else begin
            return q[DATA_W-1:0];
        end
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv2_requant.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_requant
//  Description : Combinational requantizer for one channel: adds the bias
//                scaled by 2^SHIFT to the accumulator, rounds half up,
//                shifts back down and saturates (or ReLU-clamps when
//                CONV2_DRAIN_RELU_EN is defined) to a DATA_W activation.
//  Ports       : acc  in  ACC_W   signed accumulator
//                bias in  BIAS_W  signed bias
//                res  out DATA_W  signed requantized activation
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2_requant
    import conv2_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [BIAS_W-1:0] bias,
    output logic signed [DATA_W-1:0] res
);

    logic signed [SUM_W-1:0] w_acc_ext;
    logic signed [SUM_W-1:0] w_bias_sh;
    logic signed [SUM_W-1:0] w_sum;

    assign w_acc_ext = {acc[ACC_W-1], acc};
    // Bias moved onto the accumulator's 2^SHIFT scale, sign-extended.
    assign w_bias_sh = {{(SUM_W-BIAS_W-SHIFT){bias[BIAS_W-1]}}, bias, {SHIFT{1'b0}}};
    assign w_sum     = w_acc_ext + w_bias_sh;
    assign res       = round_sat(w_sum);

endmodule
`default_nettype wire

// File: rtl/conv2_drain.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_drain
//  Description : Output drain of convolution stage 2. Buffers up to two
//                finished 16-channel accumulator vectors, adds per-channel
//                bias, requantizes to 8-bit activations and streams one
//                channel per beat over valid/ready, tracking the position
//                within a 1260-position frame.
//                Optional feature macro: CONV2_DRAIN_RELU_EN (ReLU clamp).
//  Ports       : clk        in   clock
//                rst        in   synchronous active-high reset
//                acc_in     in   CH*ACC_W packed signed accumulators
//                acc_valid  in   acc_in holds a finished position
//                b_en       in   bias write strobe (ignored while busy)
//                b_in       in   signed bias value
//                out_data   out  requantized activation
//                out_ch     out  channel index of out_data
//                out_pos    out  frame position of out_data
//                out_valid  out  out_data valid
//                out_ready  in   downstream accepts
//                frame_done out  pulse after last beat of the frame
//                overflow   out  sticky: a position was dropped
//                busy       out  buffer non-empty or beat pending
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2_drain
    import conv2_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*ACC_W-1:0]   acc_in,
    input  logic                  acc_valid,
    input  logic                  b_en,
    input  logic [BIAS_W-1:0]     b_in,
    output logic [DATA_W-1:0]     out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic [POS_W-1:0]      out_pos,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  busy
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CH_W-1:0]          r_ch;
    logic [CH_W-1:0]          w_ch_next;

    logic [CH*ACC_W-1:0]      r_buf [2];
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_count;
    logic [1:0]               w_count_next;

    logic signed [BIAS_W-1:0] r_bias [CH];
    logic [CH_W-1:0]          r_bptr;
    logic [POS_W-1:0]         r_pos;

    logic [CH*ACC_W-1:0]      w_head;
    logic signed [ACC_W-1:0]  w_acc_ch;
    logic signed [DATA_W-1:0] w_req;

    logic w_fire;
    logic w_issue;
    logic w_last;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    assign busy   = (r_count != 2'd0) || out_valid;
    assign w_fire = out_valid && out_ready;

    // The channel counter runs one beat ahead of the output register: a new
    // beat is issued whenever the register is empty or being drained, which
    // keeps one beat per cycle under continuous out_ready.
    assign w_issue = (r_state == SEND) && (!out_valid || out_ready);
    assign w_last  = w_issue && (r_ch == CH_W'(CH-1));
    assign w_pop   = w_last;
    assign w_full  = (r_count == 2'd2);
    assign w_push  = acc_valid && (!w_full || w_pop);
    assign w_drop  = acc_valid && w_full && !w_pop;
    assign w_count_next = r_count + 2'(w_push) - 2'(w_pop);

    assign w_head   = r_buf[r_rd_ptr];
    assign w_acc_ch = w_head[int'(r_ch)*ACC_W +: ACC_W];

    conv2_requant u_requant (
        .acc  (w_acc_ch),
        .bias (r_bias[r_ch]),
        .res  (w_req)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_next;
            r_ch    <= w_ch_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ch_next    = r_ch;
        case (r_state)
            IDLE: begin
                if (r_count != 2'd0) begin
                    w_state_next = SEND;
                    w_ch_next    = '0;
                end
            end
            SEND: begin
                if (w_issue) begin
                    if (w_last) begin
                        // Continue straight into the next buffered vector.
                        w_ch_next    = '0;
                        w_state_next = (w_count_next != 2'd0) ? SEND : IDLE;
                    end else begin
                        w_ch_next = r_ch + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_ch_next    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Two-entry vector buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= acc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Bias registers, loaded sequentially while the drain is quiet
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                r_bias[i] <= '0;
            end
            r_bptr <= '0;
        end else if (b_en && !busy) begin
            r_bias[r_bptr] <= b_in;
            r_bptr         <= (r_bptr == CH_W'(CH-1)) ? '0 : r_bptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Position counter (issue side, so it is attached to each beat)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos <= '0;
        end else if (w_last) begin
            r_pos <= (r_pos == POS_W'(POS_MAX-1)) ? '0 : r_pos + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register stage and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_ch     <= '0;
            out_pos    <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (w_issue) begin
                out_data  <= w_req;
                out_ch    <= r_ch;
                out_pos   <= r_pos;
                out_valid <= 1'b1;
            end else if (w_fire) begin
                out_valid <= 1'b0;
            end
            frame_done <= w_fire && (out_ch == CH_W'(CH-1))
                                 && (out_pos == POS_W'(POS_MAX-1));
            if (w_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv2_drain
//  Description : Self-checking bench for conv2_drain. Expected beats are
//                pushed to a scoreboard queue when a vector is driven and
//                compared as the DUT hands them over. Honours
//                CONV2_DRAIN_RELU_EN in its reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2_drain;
    import conv2_pkg::*;

    logic                clk;
    logic                rst;
    logic [CH*ACC_W-1:0] acc_in;
    logic                acc_valid;
    logic                b_en;
    logic [BIAS_W-1:0]   b_in;
    logic [DATA_W-1:0]   out_data;
    logic [CH_W-1:0]     out_ch;
    logic [POS_W-1:0]    out_pos;
    logic                out_valid;
    logic                out_ready;
    logic                frame_done;
    logic                overflow;
    logic                busy;

    conv2_drain dut (
        .clk        (clk),
        .rst        (rst),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .b_en       (b_en),
        .b_in       (b_in),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_pos    (out_pos),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CH_W-1:0]   ch;
        logic [POS_W-1:0]  pos;
    } beat_t;

    beat_t             sb[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    longint            bias_m [CH];
    int                exp_pos = 0;
    logic [DATA_W-1:0] last_data [CH];
    int                beat_cnt = 0;
    int                fd_cnt   = 0;
    bit                rand_ready = 1'b0;

    // Reference requantizer written directly from the arithmetic definition.
    function automatic logic [DATA_W-1:0] model_q(input longint acc, input longint bias);
        longint s;
        longint r;
        s = acc + bias * 512;
        r = (s + 256) >>> 9;
`ifdef CONV2_DRAIN_RELU_EN
        if (r < 0)   r = 0;
        if (r > 127) r = 127;
`else
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`endif
        return DATA_W'(r);
    endfunction

    function automatic logic [CH*ACC_W-1:0] rand_vec();
        logic [CH*ACC_W-1:0] v;
        logic signed [ACC_W-1:0] t;
        for (int c = 0; c < CH; c++) begin
            t = ACC_W'($urandom);
            t = t >>> (c % 12);
            v[c*ACC_W +: ACC_W] = t;
        end
        return v;
    endfunction

    function automatic logic [CH*ACC_W-1:0] const_vec(input logic signed [ACC_W-1:0] val);
        logic [CH*ACC_W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*ACC_W +: ACC_W] = val;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector for one cycle; call at posedge+1.
    task automatic send_acc(input logic [CH*ACC_W-1:0] vec, input bit accept);
        beat_t b;
        acc_in    = vec;
        acc_valid = 1'b1;
        if (accept) begin
            for (int c = 0; c < CH; c++) begin
                b.data = model_q(longint'($signed(vec[c*ACC_W +: ACC_W])), bias_m[c]);
                b.ch   = CH_W'(c);
                b.pos  = POS_W'(exp_pos);
                sb.push_back(b);
            end
            exp_pos = (exp_pos == POS_MAX - 1) ? 0 : exp_pos + 1;
        end
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int k;
        k = 0;
        while ((busy || sb.size() != 0) && k < max_cycles) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        out_ready = 1'b1;
        n_tests++;
        if (busy || sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%0b queued=%0d required busy=0 queued=0", busy, sb.size());
        end
    endtask

    task automatic load_bias(input logic [BIAS_W-1:0] val, input int idx);
        b_en = 1'b1;
        b_in = val;
        tick();
        b_en = 1'b0;
        bias_m[idx] = longint'($signed(val));
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor, sampling on the falling edge
    // ------------------------------------------------------------------
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [CH_W-1:0]   prev_ch;
    logic [POS_W-1:0]  prev_pos;
    bit                fd_exp = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        bit    acc_now;
        if (rst) begin
            prev_stall = 1'b0;
            fd_exp     = 1'b0;
        end else begin
            if (prev_stall) begin
                n_tests++;
                if ({out_valid, out_data, out_ch, out_pos} !== {1'b1, prev_data, prev_ch, prev_pos}) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%0b d=%0h ch=%0d pos=%0d required v=1 d=%0h ch=%0d pos=%0d",
                             out_valid, out_data, out_ch, out_pos, prev_data, prev_ch, prev_pos);
                end
            end
            if (frame_done || fd_exp) begin
                n_tests++;
                if (frame_done !== fd_exp) begin
                    n_fail++;
                    $display("FAIL frame_done: got %0b required %0b", frame_done, fd_exp);
                end
            end
            if (frame_done) fd_cnt++;
            acc_now = out_valid && out_ready;
            fd_exp  = 1'b0;
            if (acc_now) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: got d=%0h ch=%0d pos=%0d required no beat",
                             out_data, out_ch, out_pos);
                end else begin
                    e = sb.pop_front();
                    if ({out_data, out_ch, out_pos} !== {e.data, e.ch, e.pos}) begin
                        n_fail++;
                        $display("FAIL beat: got d=%0h ch=%0d pos=%0d required d=%0h ch=%0d pos=%0d",
                                 out_data, out_ch, out_pos, e.data, e.ch, e.pos);
                    end
                end
                last_data[out_ch] = out_data;
                beat_cnt++;
                fd_exp = (out_ch == CH_W'(CH-1)) && (out_pos == POS_W'(POS_MAX-1));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_ch    = out_ch;
            prev_pos   = out_pos;
        end
    end

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic check_reset_state(input string tag);
        n_tests++;
        if ({out_data, out_ch, out_pos, out_valid, frame_done, overflow, busy} !== '0) begin
            n_fail++;
            $display("FAIL %s: got d=%0h ch=%0d pos=%0d v=%0b fd=%0b ovf=%0b busy=%0b required all 0",
                     tag, out_data, out_ch, out_pos, out_valid, frame_done, overflow, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        check_reset_state("reset_state");
        rst = 1'b0;
        tick();
        check_reset_state("idle_after_reset");
    endtask

    task automatic test_latency();
        logic [CH*ACC_W-1:0] v;
        v = '0;
        v[0 +: ACC_W] = ACC_W'(2560);
        send_acc(v, 1'b1);                 // sampled at edge N
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_n: out_valid=%0b required 0", out_valid);
        end
        tick();                            // N+1
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_n1: out_valid=%0b required 0", out_valid);
        end
        tick();                            // N+2
        n_tests++;
        if ({out_valid, out_ch, out_data, out_pos} !== {1'b1, 4'd0, 8'd5, 11'd0}) begin
            n_fail++;
            $display("FAIL latency_n2: v=%0b ch=%0d d=%0d pos=%0d required v=1 ch=0 d=5 pos=0",
                     out_valid, out_ch, out_data, out_pos);
        end
        for (int c = 1; c < CH; c++) begin
            tick();
            n_tests++;
            if ({out_valid, out_ch} !== {1'b1, CH_W'(c)}) begin
                n_fail++;
                $display("FAIL stream_beat: v=%0b ch=%0d required v=1 ch=%0d", out_valid, out_ch, c);
            end
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_end: out_valid=%0b required 0", out_valid);
        end
        wait_drain(50);
    endtask

    task automatic test_rounding();
        logic [CH*ACC_W-1:0] v;
        v = rand_vec();
        v[0*ACC_W +: ACC_W] = ACC_W'(256);
        v[1*ACC_W +: ACC_W] = ACC_W'(255);
        v[2*ACC_W +: ACC_W] = ACC_W'(102400);
        v[3*ACC_W +: ACC_W] = ACC_W'(-1024);
        v[4*ACC_W +: ACC_W] = ACC_W'(-102400);
        v[5*ACC_W +: ACC_W] = ACC_W'(-257);
        send_acc(v, 1'b1);
        wait_drain(100);
        n_tests++;
        if ({last_data[0], last_data[1], last_data[2]} !== {8'd1, 8'd0, 8'd127}) begin
            n_fail++;
            $display("FAIL round_pos: got %0h %0h %0h required 01 00 7f", last_data[0], last_data[1], last_data[2]);
        end
        n_tests++;
`ifdef CONV2_DRAIN_RELU_EN
        if ({last_data[3], last_data[4], last_data[5]} !== {8'h00, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL round_neg: got %0h %0h %0h required 00 00 00", last_data[3], last_data[4], last_data[5]);
        end
`else
        if ({last_data[3], last_data[4], last_data[5]} !== {8'hFE, 8'h80, 8'hFF}) begin
            n_fail++;
            $display("FAIL round_neg: got %0h %0h %0h required fe 80 ff", last_data[3], last_data[4], last_data[5]);
        end
`endif
    endtask

    task automatic test_bias();
        for (int c = 0; c < CH; c++) load_bias(BIAS_W'(c), c);
        send_acc(const_vec(ACC_W'(2048)), 1'b1);
        wait_drain(100);
        for (int c = 0; c < CH; c += 5) begin
            n_tests++;
            if (last_data[c] !== DATA_W'(4 + c)) begin
                n_fail++;
                $display("FAIL bias_add ch%0d: got %0d required %0d", c, last_data[c], 4 + c);
            end
        end
        // Writes while busy must be ignored and must not move the pointer.
        send_acc(const_vec(ACC_W'(2048)), 1'b1);
        tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_send: got %0b required 1", busy);
        end
        b_en = 1'b1;
        b_in = 8'h55;
        repeat (4) tick();
        b_en = 1'b0;
        wait_drain(100);
        // Next quiet write lands in bias[0] after the wrap.
        load_bias(8'd10, 0);
        send_acc(const_vec(ACC_W'(2048)), 1'b1);
        wait_drain(100);
        n_tests++;
        if ({last_data[0], last_data[4]} !== {8'd14, 8'd8}) begin
            n_fail++;
            $display("FAIL bias_wrap: got ch0=%0d ch4=%0d required ch0=14 ch4=8", last_data[0], last_data[4]);
        end
    endtask

    task automatic test_overflow();
        int start;
        out_ready = 1'b0;
        send_acc(rand_vec(), 1'b1);
        send_acc(rand_vec(), 1'b1);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_early: got %0b required 0", overflow);
        end
        send_acc(rand_vec(), 1'b0);        // buffer full, no pop -> dropped
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set: got %0b required 1", overflow);
        end
        repeat (5) tick();
        n_tests++;
        if ({out_valid, out_ch} !== {1'b1, 4'd0}) begin
            n_fail++; $display("FAIL ovf_stall: v=%0b ch=%0d required v=1 ch=0", out_valid, out_ch);
        end
        start = beat_cnt;
        out_ready = 1'b1;
        wait_drain(200);
        n_tests++;
        if (beat_cnt - start !== 32) begin
            n_fail++; $display("FAIL ovf_beats: got %0d required 32", beat_cnt - start);
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got %0b required 1", overflow);
        end
    endtask

    task automatic test_back_to_back();
        rand_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_acc(rand_vec(), 1'b1);
            send_acc(rand_vec(), 1'b1);
            wait_drain(400);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic test_frame();
        int remaining;
        fd_cnt    = 0;
        remaining = POS_MAX - exp_pos;
        for (int i = 0; i < remaining + 2; i++) begin
            send_acc(rand_vec(), 1'b1);
            repeat (CH - 1) tick();
        end
        wait_drain(100);
        n_tests++;
        if (fd_cnt !== 1) begin
            n_fail++; $display("FAIL frame_pulses: got %0d required 1", fd_cnt);
        end
    endtask

    task automatic test_reset_mid();
        send_acc(rand_vec(), 1'b1);
        send_acc(rand_vec(), 1'b1);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        sb.delete();
        exp_pos = 0;
        for (int c = 0; c < CH; c++) bias_m[c] = 0;
        check_reset_state("reset_mid");
        rst = 1'b0;
        tick();
        check_reset_state("reset_mid_hold");
        begin
            logic [CH*ACC_W-1:0] v;
            v = '0;
            v[0 +: ACC_W] = ACC_W'(2560);
            send_acc(v, 1'b1);
        end
        wait_drain(100);
        n_tests++;
        if (last_data[0] !== 8'd5) begin
            n_fail++; $display("FAIL post_reset: got %0d required 5", last_data[0]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        acc_in    = '0;
        acc_valid = 1'b0;
        b_en      = 1'b0;
        b_in      = '0;
        out_ready = 1'b1;
        for (int c = 0; c < CH; c++) bias_m[c] = 0;
        test_reset();
        test_latency();
        test_rounding();
        test_bias();
        test_overflow();
        test_back_to_back();
        test_frame();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
